// File: rtl/wb_pkg.sv
// Shared types and constants for the RV32I write-back stage.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        CSR_NONE     = 3'b000,
        CSR_CYCLE    = 3'b001,
        CSR_CYCLEH   = 3'b010,
        CSR_INSTRET  = 3'b011,
        CSR_INSTRETH = 3'b100
    } csr_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: picks byte/halfword/word from the SRAM word and extends it.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] dm_rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = dm_rdata_i[7:0];
        case (addr_i)
            2'd0: byte_v = dm_rdata_i[7:0];
            2'd1: byte_v = dm_rdata_i[15:8];
            2'd2: byte_v = dm_rdata_i[23:16];
            2'd3: byte_v = dm_rdata_i[31:24];
            default: byte_v = dm_rdata_i[7:0];
        endcase
        // Misaligned low address bit is ignored for halfwords.
        half_v = addr_i[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
    end

    always_comb begin
        data_o = dm_rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  data_o = {24'h000000, byte_v};
            F3_LH:   data_o = {{16{half_v[15]}}, half_v};
            F3_LHU:  data_o = {16'h0000, half_v};
            F3_LW:   data_o = dm_rdata_i;
            default: data_o = dm_rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I write-back stage: result select, register-file write port, forwarding copy.
// Define WB_CSR_COUNTER_EN to build the 64-bit cycle/instret counters.
module wb_stage
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode_wb_i,
    input  logic [2:0]  funct3_wb_i,
    input  logic [4:0]  rd_wb_i,
    input  logic [31:0] pc_wb_i,
    input  logic [31:0] alu_wb_i,
    input  logic [31:0] imm_wb_i,
    input  logic [31:0] dm_rdata_i,
    input  logic [1:0]  wb_sel_wb_i,
    input  logic [2:0]  wb_sel_csr_wb_i,
    input  logic        reg_write_en_wb_i,
    input  logic        valid_wb_i,
    input  logic        stall_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_rd_o,
    output logic [31:0] fwd_data_o
);

    logic        retire;
    logic [31:0] load_data;
    logic [31:0] sel_data;
    logic [31:0] csr_data;
    logic        fwd_valid_q, fwd_valid_d;
    logic [4:0]  fwd_rd_q, fwd_rd_d;
    logic [31:0] fwd_data_q, fwd_data_d;

    // opcode only feeds checkers outside this block.
    logic unused_opcode;
    assign unused_opcode = ^opcode_wb_i;

    assign retire = valid_wb_i & ~stall_i & ~rst;

    load_align u_load_align (
        .dm_rdata_i (dm_rdata_i),
        .addr_i     (alu_wb_i[1:0]),
        .funct3_i   (funct3_wb_i),
        .data_o     (load_data)
    );

    always_comb begin
        sel_data = alu_wb_i;
        case (wb_sel_wb_i)
            WB_ALU:  sel_data = alu_wb_i;
            WB_LOAD: sel_data = load_data;
            WB_PC4:  sel_data = pc_wb_i + 32'd4;
            WB_IMM:  sel_data = imm_wb_i;
            default: sel_data = alu_wb_i;
        endcase
    end

`ifdef WB_CSR_COUNTER_EN
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q + 64'd1;
        instret_d = retire ? instret_q + 64'd1 : instret_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    // Reads see the pre-increment value, so instret excludes the reader.
    always_comb begin
        csr_data = '0;
        case (wb_sel_csr_wb_i)
            CSR_CYCLE:    csr_data = cycle_q[31:0];
            CSR_CYCLEH:   csr_data = cycle_q[63:32];
            CSR_INSTRET:  csr_data = instret_q[31:0];
            CSR_INSTRETH: csr_data = instret_q[63:32];
            default:      csr_data = '0;
        endcase
    end
`else
    assign csr_data = '0;
`endif

    assign rf_we_o    = retire & reg_write_en_wb_i & (rd_wb_i != 5'd0);
    assign rf_waddr_o = rd_wb_i;
    assign rf_wdata_o = (wb_sel_csr_wb_i != CSR_NONE) ? csr_data : sel_data;

    // Forwarding copy keeps the last written rd/data; only valid drops.
    always_comb begin
        fwd_valid_d = rf_we_o;
        fwd_rd_d    = rf_we_o ? rf_waddr_o : fwd_rd_q;
        fwd_data_d  = rf_we_o ? rf_wdata_o : fwd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
            fwd_rd_q    <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_rd_q    <= fwd_rd_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign fwd_valid_o = fwd_valid_q;
    assign fwd_rd_o    = fwd_rd_q;
    assign fwd_data_o  = fwd_data_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 5-stage RV32I core, consuming the MEM/WB pipeline register outputs and the data-SRAM read data, which bypasses MEM/WB and arrives directly in WB. Selects the write-back value (ALU, aligned/extended load, PC+4, immediate, or counter CSR) and drives the register-file write port. Owns the 64-bit cycle/instret counters and a one-cycle registered forwarding copy of the last register write.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- opcode_wb_i  in  7  opcode of WB instruction
- funct3_wb_i  in  3  funct3, selects load width/sign
- rd_wb_i  in  5  destination register
- pc_wb_i  in  32  instruction PC
- alu_wb_i  in  32  ALU result / load address
- imm_wb_i  in  32  immediate
- dm_rdata_i  in  32  data-SRAM read word
- wb_sel_wb_i  in  2  write-back source select
- wb_sel_csr_wb_i  in  3  counter CSR select
- reg_write_en_wb_i  in  1  instruction writes rd
- valid_wb_i  in  1  WB slot holds a real instruction
- stall_i  in  1  pipeline stall; WB instruction does not retire this cycle
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  32  register-file write data
- fwd_valid_o  out  1  registered: previous cycle wrote a register
- fwd_rd_o  out  5  registered write address
- fwd_data_o  out  32  registered write data

## Operation
- retire = valid_wb_i & ~stall_i & ~rst.
- rf_we_o = retire & reg_write_en_wb_i & (rd_wb_i != 0). rf_waddr_o = rd_wb_i.
- wb_sel: 00 alu_wb_i; 01 load data; 10 pc_wb_i + 4 (mod 2^32); 11 imm_wb_i.
- wb_sel_csr nonzero overrides wb_sel: 001 cycle[31:0], 010 cycle[63:32], 011 instret[31:0], 100 instret[63:32]; 101–111 return 0.
- Load alignment uses alu_wb_i[1:0]:
  - LB/LBU (000/100): byte alu[1:0], sign-/zero-extended.
  - LH/LHU (001/101): halfword alu[1], with alu[0] ignored.
  - LW (010): full word, with alu[1:0] ignored.
  - Other funct3 values: full word.
- cycle: 64-bit, increments every non-reset cycle, including during stalls.
- instret: 64-bit, increments on retire only.
- Both counters wrap from 2^64-1 to 0.
- A CSR read returns the registered value before the current cycle's increment, so an instret read excludes the reading instruction. Low-to-high carry is visible to a high-word read only in the following cycle.
- opcode_wb_i is unused for selection and is exposed only for assertions.

## Timing
- rf_we_o, rf_waddr_o and rf_wdata_o are combinational from the inputs and counters. There is zero-latency write, and the register file writes at the clock edge.
- fwd_valid_o, fwd_rd_o and fwd_data_o capture rf_we_o, rf_waddr_o and rf_wdata_o each edge, giving 1-cycle latency. When rf_we_o=0, fwd_valid_o goes to 0 and fwd_rd_o/fwd_data_o hold their values.
- Reset values: cycle=0, instret=0, fwd_valid_o=0, fwd_rd_o=0, fwd_data_o=0. rf_we_o=0 while rst is high.
- Reset asserted mid-operation: the instruction in WB is dropped (no write, no instret increment), and counters read 0 the cycle after reset deasserts.
- With stall_i high the same instruction is presented again the next cycle. No write and no count occur until the cycle stall_i is low.

## Configuration
- WB_CSR_COUNTER_EN defined: cycle/instret counters are built and readable as above.
- WB_CSR_COUNTER_EN undefined: no counter flops. Any nonzero wb_sel_csr_wb_i selects 0 as write data, and rf_we_o behaviour is unchanged.

## Structure
- Shared package wb_pkg holds:
  - wb_sel_e (ALU/LOAD/PC4/IMM)
  - csr_sel_e (NONE/CYCLE/CYCLEH/INSTRET/INSTRETH)
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
- Sub-module load_align: combinational, with inputs dm_rdata, addr[1:0], funct3 and output a 32-bit extended value.
- Counters and forwarding registers live in wb_stage.

## Test plan
- LB, dm_rdata_i=0x80FF7F01, alu[1:0]=3, rd=5, retire -> rf_wdata_o=0xFFFFFF80, rf_we_o=1. Same stimulus with LBU -> 0x00000080. Same with LHU, alu[1:0]=2 -> 0x000080FF.
- wb_sel=10, pc=0xFFFFFFFC -> rf_wdata_o=0x00000000. wb_sel=11, imm=0x12345000 -> 0x12345000.
- rd=0, reg_write_en=1 -> rf_we_o=0, and the next cycle fwd_valid_o=0.
- Reset, then 10 cycles with 4 retires, then a read of csr_sel=011 -> 4. csr_sel=001 on the 11th post-reset cycle -> 10.
- Preload (force) cycle=0x00000000_FFFFFFFF: a read of CYCLEH that cycle -> 0, the next cycle -> 1, and the low word wraps to 0.
- valid=1, stall_i=1 for 3 cycles, then 0 -> one write only, instret +1, and fwd_valid_o=1 exactly one cycle after the write. Asserting rst mid-stall -> no write, and all counters/fwd outputs read 0.
